period_meter: RTL and testbench

//   Receiving end of the clock-divider/counter chain: takes a divided pulse train
//   (e.g. a modulo-counter output) and measures its period and high time in clk cycles.

---
 rtl/period_meter.sv | 101 ++++++++++
 tb/tb_period_meter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures rise-to-rise period and high time of an asynchronous pulse train in clk cycles,
// with a one-cycle valid strobe, a lock level and a sticky overflow flag.
module period_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cycles,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic             s_prev_reg;
  logic             s, rise;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] period_next, high_next;
  logic             valid_next, locked_next, overflow_next;

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= '0;
      s_prev_reg  <= 1'b0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hcnt_reg    <= '0;
      period      <= '0;
      high_cycles <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      s_prev_reg  <= s;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hcnt_reg    <= hcnt_next;
      period      <= period_next;
      high_cycles <= high_next;
      valid       <= valid_next;
      locked      <= locked_next;
      overflow    <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    hcnt_next     = hcnt_reg;
    period_next   = period;
    high_next     = high_cycles;
    valid_next    = 1'b0;
    locked_next   = locked;
    overflow_next = overflow;
    case (state_reg)
      IDLE: begin
        // First rise only arms the counters; no measurement exists yet.
        if (rise) begin
          cnt_next   = CNT_ONE;
          hcnt_next  = CNT_ONE;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_next   = cnt_reg;
          high_next     = hcnt_reg;
          valid_next    = 1'b1;
          locked_next   = 1'b1;
          overflow_next = 1'b0;
          cnt_next      = CNT_ONE;
          hcnt_next     = CNT_ONE;
        end else if (cnt_reg == CNT_MAX) begin
          overflow_next = 1'b1;
          locked_next   = 1'b0;
          state_next    = IDLE;
        end else begin
          // hcnt is bounded by cnt, so it cannot wrap before cnt saturates.
          cnt_next = cnt_reg + CNT_ONE;
          if (s) hcnt_next = hcnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected measurements, a monitor
// pops and compares on every valid strobe.
module tb_period_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic [7:0] period, high_cycles;
  logic       valid, locked, overflow;

  typedef struct {
    int p;
    int h;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   last_rise = 0;

  period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(period),
    .high_cycles(high_cycles), .valid(valid), .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_period"}, int'(period), 0);
    chk({name, "_high"}, int'(high_cycles), 0);
    chk({name, "_flags"}, int'({valid, locked, overflow}), 0);
  endtask

  // Drive one pulse starting with a raw rise; the rise optionally completes a measurement.
  task automatic pulse(input int h, input int l, input bit exp_v, input int ep, input int eh);
    exp_t e;
    sig_in = 1'b1;
    last_rise = cyc;
    if (exp_v) begin
      e.p = ep; e.h = eh; e.c = cyc + 3;
      exp_q.push_back(e);
    end
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d with no pending expectation (cycle %0d)",
                 period, high_cycles, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.c);
        chk("period", int'(period), e.p);
        chk("high_cycles", int'(high_cycles), e.h);
        chk("locked_at_valid", int'(locked), 1);
        chk("overflow_at_valid", int'(overflow), 0);
        $display("txn: cycle %0d period=%0d high=%0d expected %0d/%0d", cyc, period, high_cycles, e.p, e.h);
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 30000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("reset");
      sig_in = ~sig_in;
    end
    rst = 1'b0;
    sig_in = 1'b0;
    repeat (4) @(negedge clk);

    // Square wave 12/6: first rise arms, the rest measure
    pulse(6, 6, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) pulse(6, 6, 1'b1, 12, 6);
    // Switch to 8/4 then back to 12/6
    pulse(4, 4, 1'b1, 12, 6);
    for (int i = 0; i < 3; i++) pulse(4, 4, 1'b1, 8, 4);
    pulse(6, 6, 1'b1, 8, 4);
    pulse(6, 6, 1'b1, 12, 6);
    // Lock at 8, then hold low until overflow
    pulse(4, 4, 1'b1, 12, 6);
    pulse(4, 0, 1'b1, 8, 4);
    while (cyc < last_rise + 257) @(negedge clk);
    chk("ovf_not_early", int'(overflow), 0);
    @(negedge clk);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_unlocked", int'(locked), 0);
    chk("ovf_period_hold", int'(period), 8);
    chk("ovf_high_hold", int'(high_cycles), 4);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", int'(overflow), 1);
    // Recover with two rises 10 apart
    pulse(5, 5, 1'b0, 0, 0);
    pulse(5, 5, 1'b1, 10, 5);
    // Minimum period
    pulse(1, 1, 1'b1, 10, 5);
    pulse(1, 1, 1'b1, 2, 1);
    pulse(1, 1, 1'b1, 2, 1);
    // Maximum period 255, then 256 which overflows
    pulse(1, 254, 1'b1, 2, 1);
    pulse(1, 254, 1'b1, 255, 1);
    pulse(1, 255, 1'b1, 255, 1);
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("n256_overflow", int'(overflow), 1);
    chk("n256_unlocked", int'(locked), 0);
    chk("n256_period_hold", int'(period), 255);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    // Re-lock at 4/2, then reset 5 cycles after a rise
    pulse(3, 2, 1'b1, 4, 2);
    chk("prereset_locked", int'(locked), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midreset");
    repeat (3) @(negedge clk);
    pulse(3, 3, 1'b0, 0, 0);
    pulse(3, 3, 1'b1, 6, 3);
    repeat (10) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
